// File: rtl/scanner_7seg_refresh.sv
// scanner_7seg_refresh: 4-digit 7-segment scanner with a blanking gap between digits.
// Optional macro SCANNER_7SEG_BRILLO_PWM_EN adds a 3-bit brightness PWM on the anodes.
module scanner_7seg_refresh #(
    parameter int CLK_DIV      = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       habilitar,
`ifdef SCANNER_7SEG_BRILLO_PWM_EN
    input  logic [2:0] brillo,
`endif
    input  logic [0:6] msj_seleccionado,
    output logic [1:0] seleccion,
    output logic [0:6] segmentos,
    output logic [3:0] anodos,
    output logic       fin_ciclo
);
    localparam int MX = CLK_DIV > BLANK_CYCLES ? CLK_DIV : BLANK_CYCLES;
    localparam int CW = MX > 1 ? $clog2(MX) : 1;
    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] SHOW  = 1'b1;

    logic [0:0]    r_estado;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_sel;
    logic [0:6]    r_pat;
    logic [0:6]    r_seg;
    logic [3:0]    r_an;
    logic          r_fin;
    logic          w_last_blank;
    logic          w_last_show;
    logic          w_lit;
    logic          w_on;

    assign w_last_blank = r_cnt == CW'(BLANK_CYCLES - 1);
    assign w_last_show  = r_cnt == CW'(CLK_DIV - 1);
    assign w_lit        = habilitar && r_estado == SHOW;

`ifdef SCANNER_7SEG_BRILLO_PWM_EN
    logic [2:0] r_pwm;
    logic [2:0] w_pwm_nxt;
    assign w_pwm_nxt = r_pwm + 3'd1;
    // Compare the value pwm will hold while the registered anode is visible.
    assign w_on = w_pwm_nxt <= brillo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_pwm <= '0;
        else        r_pwm <= w_pwm_nxt;
    end
`else
    assign w_on = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado <= BLANK;
            r_cnt    <= '0;
            r_sel    <= '0;
            r_pat    <= '1;
            r_seg    <= '1;
            r_an     <= 4'hF;
            r_fin    <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            // A pause always resumes from a fresh BLANK, so parking there is equivalent to freezing.
            if (!habilitar) begin
                r_estado <= BLANK;
                r_cnt    <= '0;
            end else if (r_estado == BLANK) begin
                if (w_last_blank) begin
                    r_pat    <= msj_seleccionado;
                    r_cnt    <= '0;
                    r_estado <= SHOW;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else if (w_last_show) begin
                r_sel    <= r_sel + 2'd1;
                r_cnt    <= '0;
                r_estado <= BLANK;
                r_fin    <= r_sel == 2'd3;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_an  <= (w_lit && w_on) ? ~(4'b0001 << r_sel) : 4'hF;
            r_seg <= w_lit ? r_pat : '1;
        end
    end

    assign seleccion = r_sel;
    assign segmentos = r_seg;
    assign anodos    = r_an;
    assign fin_ciclo = r_fin;
endmodule

// File: tb/tb_scanner_7seg_refresh.sv
// tb_scanner_7seg_refresh: randomized scoreboard bench for scanner_7seg_refresh.
// A cycle-index reference model queues expected outputs; a monitor pops and compares.
module tb_scanner_7seg_refresh;
    localparam int CD = 4;
    localparam int BC = 2;
    localparam int P  = CD + BC;

    typedef struct packed {
        logic [1:0] s;
        logic [3:0] a;
        logic [6:0] g;
        logic       f;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       habilitar = 1'b1;
    logic       ovr_en = 1'b0;
    logic [6:0] ovr = '0;
    logic [0:6] msj;
    logic [1:0] seleccion;
    logic [0:6] segmentos;
    logic [3:0] anodos;
    logic       fin_ciclo;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    exp_t q[$];

    int n = 0, base = 0, cur = 0;
    logic [6:0] cap = '1;

    always #5 clk = ~clk;

    // Mux model: digit k returns 7'h0k unless the bench overrides it.
    assign msj = ovr_en ? ovr : {5'b0, seleccion};

    scanner_7seg_refresh #(.CLK_DIV(CD), .BLANK_CYCLES(BC)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .habilitar(habilitar),
`ifdef SCANNER_7SEG_BRILLO_PWM_EN
        .brillo(3'd7),
`endif
        .msj_seleccionado(msj),
        .seleccion(seleccion),
        .segmentos(segmentos),
        .anodos(anodos),
        .fin_ciclo(fin_ciclo)
    );

    // Reference: n counts enabled cycles since the last restart from BLANK with digit base.
    always @(posedge clk) begin : model
        exp_t e;
        int m, dig;
        logic lit;
        logic [6:0] mux;
        if (!rst_n) begin
            n = 0; base = 0; cur = 0;
            e = '{2'd0, 4'hF, 7'h7F, 1'b0};
        end else if (!habilitar) begin
            n = 0; base = cur;
            e = '{cur[1:0], 4'hF, 7'h7F, 1'b0};
        end else begin
            mux = ovr_en ? ovr : {5'b0, cur[1:0]};
            n++;
            m = n - 1;
            if (m % P == BC - 1) cap = mux;
            lit = (m % P) >= BC;
            dig = (base + m / P) % 4;
            e.a = lit ? ~(4'b0001 << dig) : 4'hF;
            e.g = lit ? cap : 7'h7F;
            e.f = (n % P == 0) && ((base + n / P - 1) % 4 == 3);
            cur = (base + n / P) % 4;
            e.s = cur[1:0];
        end
        q.push_back(e);
    end

    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        cyc++;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL scoreboard_empty cyc=%0d got=none required=entry", cyc);
        end else begin
            e = q.pop_front();
            if (seleccion !== e.s || anodos !== e.a || segmentos !== e.g || fin_ciclo !== e.f) begin
                fails++;
                $display("FAIL scan cyc=%0d got sel=%0d an=%b seg=%h fin=%b required sel=%0d an=%b seg=%h fin=%b",
                         cyc, seleccion, anodos, segmentos, fin_ciclo, e.s, e.a, e.g, e.f);
            end
        end
        tests++;
        if ($countones(~anodos) > 1) begin
            fails++;
            $display("FAIL one_anode cyc=%0d got an=%b required at most one low", cyc, anodos);
        end
    end

    task automatic chk_reset(input string nm);
        #1;
        tests++;
        if (anodos !== 4'hF || segmentos !== 7'h7F || seleccion !== 2'd0 || fin_ciclo !== 1'b0) begin
            fails++;
            $display("FAIL %s got an=%b seg=%h sel=%0d fin=%b required an=1111 seg=7f sel=0 fin=0",
                     nm, anodos, segmentos, seleccion, fin_ciclo);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        chk_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("power_on_reset");
        rst_n = 1'b1;
        repeat (2 * 4 * P) @(negedge clk);
        // Override the mux while digit 2 is lit; the shown pattern must not follow it.
        do_reset();
        repeat (3 * P - 3) @(negedge clk);
        repeat (3) begin
            ovr_en = 1'b1;
            ovr = 7'($urandom);
            @(negedge clk);
        end
        ovr_en = 1'b0;
        repeat (2 * P) @(negedge clk);
        // Pause for 5 cycles during digit 1.
        do_reset();
        repeat (P + BC + 1) @(negedge clk);
        habilitar = 1'b0;
        repeat (5) @(negedge clk);
        habilitar = 1'b1;
        repeat (3 * P) @(negedge clk);
        // Reset while digit 3 is lit, then watch the restart.
        do_reset();
        repeat (3 * P + BC + 2) @(negedge clk);
        do_reset();
        repeat (5 * P) @(negedge clk);
        repeat (600) begin
            @(negedge clk);
            habilitar = $urandom_range(0, 9) != 0;
            ovr_en = $urandom_range(0, 3) == 0;
            ovr = 7'($urandom);
            if ($urandom_range(0, 199) == 0) do_reset();
        end
        habilitar = 1'b1;
        ovr_en = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/scanner_7seg_refresh.md
Name: scanner_7seg_refresh

Overview:
- Time-multiplexed driver for a 4-digit 7-segment display. It is the counterpart of the 4:1 message mux.
- Generates the 2-bit `seleccion` that feeds the mux and takes the selected 7-bit pattern back. Registers that pattern and drives the segment lines and active-low anodes.
- Inserts a blanking gap between digits to prevent ghosting.
- Sits between the message-selection logic and the board's display pins.

Parameters:
- CLK_DIV, 50000: cycles each digit is lit (SHOW length). Must be >= 1.
- BLANK_CYCLES, 4: cycles all digits are dark between digits (BLANK length). Must be >= 1.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- habilitar  input  1  1 = scan normally; 0 = display dark, counters frozen.
- msj_seleccionado  input  7 [0:6]  segment pattern returned by the mux for the current `seleccion`; bit 0 = segment a … bit 6 = segment g.
- seleccion  output  2  digit index driven to the mux select.
- segmentos  output  7 [0:6]  registered segment lines, passed bit-for-bit; all 1 = dark.
- anodos  output  4  active-low digit enables; anodos[i]=0 lights digit i.
- fin_ciclo  output  1  one-cycle pulse when `seleccion` wraps 3->0.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values:
  - estado=BLANK, seleccion=0, anodos=4'b1111, segmentos=7'b1111111, fin_ciclo=0.
  - Both cycle counters are 0.
  - Asserting rst_n mid-operation forces the reset values immediately, whatever the state.
- FSM states: BLANK, SHOW. One counter `cnt` serves both states, width clog2(max(CLK_DIV,BLANK_CYCLES)).
- BLANK:
  - anodos=1111, segmentos=1111111. `seleccion` holds its value; the mux output is combinational and settles.
  - On the cycle where cnt==BLANK_CYCLES-1: capture msj_seleccionado into the segment register, clear cnt, go to SHOW.
  - Otherwise cnt increments.
- SHOW:
  - anodos has only bit `seleccion` low; segmentos = captured pattern.
  - Changes to msj_seleccionado during SHOW do not affect the display; the pattern is captured once per digit.
  - On the cycle where cnt==CLK_DIV-1:
    - seleccion <= seleccion+1 mod 4, so 3 wraps to 0.
    - cnt <= 0, go to BLANK.
    - If the old seleccion was 3, fin_ciclo=1 for the following single cycle.
- Timing after reset release:
  - First lit cycle is cycle BLANK_CYCLES+1; cycle 1 is the first edge with rst_n high.
  - Digit period = CLK_DIV+BLANK_CYCLES. Full frame = 4*(CLK_DIV+BLANK_CYCLES).
- habilitar=0:
  - At the next edge, anodos=1111 and segmentos=1111111.
  - estado, cnt and seleccion freeze; fin_ciclo=0.
- habilitar returns to 1:
  - FSM enters BLANK with cnt=0 and keeps the frozen seleccion.
  - A fresh capture follows, so a stale pattern is never shown.
- Invariants: never more than one anodos bit low; no anode is low during BLANK.

Optional Feature:
- Macro: SCANNER_7SEG_BRILLO_PWM_EN.
- When defined:
  - Adds input `brillo` [2:0].
  - A free-running 3-bit counter `pwm` increments every cycle and is reset to 0.
  - During SHOW, the selected anode is driven low only when pwm <= brillo; otherwise anodos=1111.
  - brillo=7 gives full-on; brillo=0 gives a 1/8 duty.
  - Segments, FSM and seleccion timing are unchanged.
- When undefined: no `brillo` port; the anode is low for all SHOW cycles.

Test Plan (CLK_DIV=4, BLANK_CYCLES=2):
- Reset then release, with the mux model returning msj_k = 7'h0k for seleccion=k.
  - Required: cycles 1-2 dark.
  - Required: cycles 3-6 anodos=1110, segmentos=7'h00.
  - Required: cycles 7-8 dark with seleccion=1.
  - Required: cycles 9-12 anodos=1101, segmentos=7'h01.
- Run a full frame.
  - Required: digits light in the order 0,1,2,3, each for 4 cycles with 2 dark cycles between.
  - Required: seleccion wraps 3->0.
  - Required: fin_ciclo is high exactly once per 24 cycles, on the cycle after digit 3's last SHOW cycle.
- Toggle msj_seleccionado during SHOW of digit 2.
  - Required: segmentos unchanged until the next capture.
  - Required: at most one anode is low at any cycle.
- Drop habilitar for 5 cycles mid-SHOW of digit 1.
  - Required: dark during those cycles.
  - Required: after restore, 2 dark cycles then digit 1 shown for a full 4 cycles.
- Assert rst_n low mid-SHOW of digit 3.
  - Required: immediately anodos=1111, segmentos=1111111, seleccion=0.
  - Required: on release, the sequence restarts per the first scenario.
- With SCANNER_7SEG_BRILLO_PWM_EN defined, CLK_DIV=16, brillo=1.
  - Required: within a SHOW window, the anode is low only on cycles where pwm is 0 or 1 (2 of every 8).
  - Required: segment timing is identical to the undefined build.
